// File: rtl/spi_flash_responder.sv
// Purpose : single-bit SPI (mode 0) flash target answering READ 0x03, FAST READ 0x0B and
//           JEDEC ID 0x9F, serving read data from a byte-wide synchronous memory port.
// Latency : SYNC_STAGES+1 clk_i from any pin edge to its effect (miso updated after sck fall).
// Backpressure: none; clk_i must be >= 8x the SPI clock and memory answers one clk_i after mem_re_o.
// Ports   : clk_i/rstn_i system clock and async active-low reset; spi_csb_i/spi_clk_i/spi_mosi_i
//           raw SPI pins; spi_miso_o/spi_miso_oe_o io1 data and tristate enable;
//           mem_re_o/mem_addr_o/mem_rdata_i backing memory read port; busy_o selected; cmd_o last cmd.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        spi_csb_i,
  input  logic        spi_clk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  output logic        mem_re_o,
  output logic [23:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o,
  output logic [7:0]  cmd_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_IGNORE
  } state_e;

  // Pin synchronizers; csb idles deselected so a reset never looks like a select.
  logic [SYNC_STAGES-1:0] csb_sync_q, sck_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  logic                   csb_s, sck_s, mosi_s, sck_rise, sck_fall;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      csb_sync_q  <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
    end
  end

  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [1:0]  byte_cnt_q;      // address byte index, or JEDEC byte index in ID
  logic [22:0] shin_q;          // 23 stored bits plus the live mosi bit form the 24-bit word
  logic [7:0]  shout_q, hold_q;
  logic        dummy_q, first_q;
  logic        rd_vld_q;        // mem_rdata_i valid this cycle
  logic        rd_to_shout_q;   // outstanding read is the first byte of the burst
  logic        pf_pend_q;       // prefetch waits one cycle so mem_re_o never repeats back-to-back
  logic        miso_q, oe_q, re_q, busy_q;
  logic [23:0] addr_q;
  logic [7:0]  cmd_q;
  logic [23:0] in_word;
  logic [7:0]  next_byte;

  assign in_word = {shin_q, mosi_s};

  // Byte loaded at a byte boundary: prefetched memory data or the next JEDEC byte (then 0xFF).
  always_comb begin
    next_byte = 8'hFF;
    if (state_q == S_DATA)       next_byte = hold_q;
    else if (byte_cnt_q == 2'd1) next_byte = JEDEC_ID[15:8];
    else if (byte_cnt_q == 2'd2) next_byte = JEDEC_ID[7:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 2'd0;
      shin_q        <= '0;
      shout_q       <= 8'h00;
      hold_q        <= 8'h00;
      dummy_q       <= 1'b0;
      first_q       <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_to_shout_q <= 1'b0;
      pf_pend_q     <= 1'b0;
      miso_q        <= 1'b0;
      oe_q          <= 1'b0;
      re_q          <= 1'b0;
      busy_q        <= 1'b0;
      addr_q        <= 24'h000000;
      cmd_q         <= 8'h00;
    end else begin
      re_q     <= 1'b0;
      rd_vld_q <= re_q;
      if (csb_s) begin
        // Deselect wins over everything, including a coincident sck edge.
        state_q       <= S_IDLE;
        oe_q          <= 1'b0;
        miso_q        <= 1'b0;
        busy_q        <= 1'b0;
        rd_vld_q      <= 1'b0;
        rd_to_shout_q <= 1'b0;
        pf_pend_q     <= 1'b0;
      end else begin
        if (rd_vld_q) begin
          if (rd_to_shout_q) begin
            shout_q       <= mem_rdata_i;
            rd_to_shout_q <= 1'b0;
            addr_q        <= addr_q + 24'd1;
            pf_pend_q     <= 1'b1;
          end else begin
            hold_q <= mem_rdata_i;
          end
        end
        if (pf_pend_q) begin
          re_q      <= 1'b1;
          pf_pend_q <= 1'b0;
        end
        case (state_q)
          S_IDLE: begin
            state_q   <= S_CMD;
            busy_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
          end
          S_CMD: if (sck_rise) begin
            shin_q    <= in_word[22:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              cmd_q      <= in_word[7:0];
              byte_cnt_q <= 2'd0;
              dummy_q    <= 1'b0;
              case (in_word[7:0])
                8'h03: state_q <= S_ADDR;
                8'h0B: begin
                  state_q <= S_ADDR;
                  dummy_q <= 1'b1;
                end
                8'h9F: begin
                  state_q    <= S_ID;
                  shout_q    <= JEDEC_ID[23:16];
                  byte_cnt_q <= 2'd1;
                  oe_q       <= 1'b1;
                  first_q    <= 1'b1;
                end
                default: state_q <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: if (sck_rise) begin
            shin_q    <= in_word[22:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == 2'd2) begin
                addr_q        <= in_word;
                re_q          <= 1'b1;
                rd_to_shout_q <= 1'b1;
                first_q       <= 1'b1;
                if (dummy_q) begin
                  state_q <= S_DUMMY;
                end else begin
                  state_q <= S_DATA;
                  oe_q    <= 1'b1;
                end
              end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
            end
          end
          S_DUMMY: if (sck_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_DATA;
              oe_q    <= 1'b1;
            end
          end
          S_DATA, S_ID: if (sck_fall) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            first_q   <= 1'b0;
            if (bit_cnt_q == 3'd0 && !first_q) begin
              // Byte boundary: move the next byte in and, for memory reads, prefetch again.
              miso_q  <= next_byte[7];
              shout_q <= {next_byte[6:0], 1'b0};
              if (state_q == S_DATA) begin
                addr_q <= addr_q + 24'd1;
                re_q   <= 1'b1;
              end else if (byte_cnt_q != 2'd3) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
            end else begin
              miso_q  <= shout_q[7];
              shout_q <= {shout_q[6:0], 1'b0};
            end
          end
          default: ;  // S_IGNORE: wait for deselect
        endcase
      end
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign mem_re_o      = re_q;
  assign mem_addr_o    = addr_q;
  assign busy_o        = busy_q;
  assign cmd_o         = cmd_q;

endmodule
